systolic_deskew: RTL

SYSTOLIC_DESKEW -- requirements
Module: systolic_deskew

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/deskew_fifo.sv | 58 +++++
 rtl/systolic_deskew.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic output deskew block.
// Holds the lane-data type, the RUN/ERR state encoding and the stats counter width.
package systolic_pkg;

  localparam int LANE_W  = 8;
  localparam int STATS_W = 16;

  typedef logic [LANE_W-1:0] lane_data_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  // Upstream back-pressure point: leave room for the rows already in flight.
  function automatic int af_threshold(input int depth, input int lanes);
    return (depth - lanes < 1) ? 1 : depth - lanes;
  endfunction

endpackage

// File: rtl/deskew_fifo.sv
// First-word-fall-through FIFO holding aligned rows; read data is zero while empty.
// A push is accepted when full only if a pop happens on the same edge.
module deskew_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale entries from the read port.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/systolic_deskew.sv
// Realigns skewed systolic-array output lanes into whole rows and buffers them in a FIFO.
// Optional macro SYSTOLIC_DESKEW_STATS_EN adds a 16-bit popped-word counter (row_count).
module systolic_deskew
  import systolic_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = LANE_W,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   almost_full,
  input  logic                   err_clr,
  output logic                   overflow_err,
  output logic                   skew_err
`ifdef SYSTOLIC_DESKEW_STATS_EN
  ,
  output logic [STATS_W-1:0]     row_count
`endif
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int AF_THR = af_threshold(DEPTH, LANES);

  logic [LANES-1:0]       w_al_valid;
  logic [LANES*WIDTH-1:0] w_al_data;
  logic                   w_row_full;
  logic                   w_row_mixed;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_ovf_evt;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_count;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ovf_err;
  logic                   r_skew_err;

  // Lane i waits LANES-1-i cycles so every lane of a row lines up with the last lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int D = LANES - 1 - g;
    if (D == 0) begin : g_direct
      assign w_al_valid[g]              = in_valid[g];
      assign w_al_data[g*WIDTH +: WIDTH] = in_data[g*WIDTH +: WIDTH];
    end else begin : g_delay
      logic [D-1:0]            r_v;
      logic [D-1:0][WIDTH-1:0] r_d;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_v <= '0;
          r_d <= '0;
        end else begin
          r_v[0] <= in_valid[g];
          r_d[0] <= in_data[g*WIDTH +: WIDTH];
          for (int s = 1; s < D; s++) begin
            r_v[s] <= r_v[s-1];
            r_d[s] <= r_d[s-1];
          end
        end
      end

      assign w_al_valid[g]               = r_v[D-1];
      assign w_al_data[g*WIDTH +: WIDTH] = r_d[D-1];
    end
  end

  assign w_row_full  = &w_al_valid;
  assign w_row_mixed = (|w_al_valid) & ~w_row_full;
  assign w_pop       = out_valid & out_ready;
  assign w_ovf_evt   = w_row_full & w_fifo_full & ~w_pop;
  assign w_push      = w_row_full & (r_state == ST_RUN) & (~w_fifo_full | w_pop);

  deskew_fifo #(
    .WIDTH (LANES*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_al_data),
    .o_rdata (out_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign out_valid   = ~w_fifo_empty;
  assign almost_full = (w_count >= CW'(AF_THR));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next-state gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: if (w_ovf_evt | w_row_mixed) w_state_nxt = ST_ERR;
      ST_ERR: if (err_clr & ~(w_ovf_evt | w_row_mixed)) w_state_nxt = ST_RUN;
    endcase
  end

  // A new error event on the clear edge wins over the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf_err  <= 1'b0;
      r_skew_err <= 1'b0;
    end else if (err_clr) begin
      r_ovf_err  <= w_ovf_evt;
      r_skew_err <= w_row_mixed;
    end else begin
      r_ovf_err  <= r_ovf_err | w_ovf_evt;
      r_skew_err <= r_skew_err | w_row_mixed;
    end
  end

  assign overflow_err = r_ovf_err;
  assign skew_err     = r_skew_err;

`ifdef SYSTOLIC_DESKEW_STATS_EN
  logic [STATS_W-1:0] r_row_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_row_count <= '0;
    else if (w_pop) r_row_count <= r_row_count + 1'b1;
  end

  assign row_count = r_row_count;
`endif

endmodule
